// File: rtl/osecpu_led_pkg.sv
// Shared constants and state encoding for the LED display scheduler.
package osecpu_led_pkg;

  localparam int unsigned NSRC = 4;

  // Defaults shared by the top level and its bench.
  localparam int unsigned DWELL_DEFAULT      = 50_000_000;
  localparam int unsigned ALERT_HOLD_DEFAULT = 100_000_000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShow  = 2'd1,
    StAlert = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_rr_next.sv
// Combinational round-robin finder: first valid source after start, wrapping to start itself.
module led_rr_next
  import osecpu_led_pkg::*;
(
  input  logic [NSRC-1:0] valid,
  input  logic [1:0]      start,
  output logic [1:0]      idx,
  output logic            found
);

  // Walk offsets from farthest to nearest so the nearest valid candidate wins.
  always_comb begin
    idx   = start;
    found = 1'b0;
    for (int off = NSRC; off >= 1; off--) begin
      if (valid[start + 2'(off)]) begin
        idx   = start + 2'(off);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_disp_sched.sv
// Shares one 4-digit display between four status sources: rotation, pin and alert override.
module led_disp_sched
  import osecpu_led_pkg::*;
#(
  parameter int unsigned DWELL      = DWELL_DEFAULT,
  parameter int unsigned ALERT_HOLD = ALERT_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   load,
  input  logic [NSRC-1:0]   clear,
  input  logic [16*NSRC-1:0] src_data,
  input  logic              pin_en,
  input  logic [1:0]        pin_sel,
  input  logic              alert,
  output logic [15:0]       data,
  output logic [1:0]        cur_src,
  output logic              any_valid,
  output logic              switched
);

  // One down-counter serves both dwell and alert hold.
  localparam int unsigned CW = $clog2(max_u(DWELL, ALERT_HOLD));
  localparam logic [CW-1:0] DwellLoad = CW'(DWELL - 1);
  localparam logic [CW-1:0] HoldLoad  = CW'(ALERT_HOLD - 1);

  state_e          state_q, state_d;
  logic [1:0]      cur_q, cur_d;
  logic [1:0]      saved_q, saved_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     snap_q [NSRC];
  logic [15:0]     snap_d [NSRC];
  logic [NSRC-1:0] valid_q, valid_d;
  logic [15:0]     data_q, data_d;
  logic            any_q;
  logic            sw_q, sw_d;

  logic [1:0]      cur_next, saved_next;
  logic            cur_found, saved_found;

  led_rr_next u_next_cur (
    .valid (valid_q),
    .start (cur_q),
    .idx   (cur_next),
    .found (cur_found)
  );

  led_rr_next u_next_saved (
    .valid (valid_q),
    .start (saved_q),
    .idx   (saved_next),
    .found (saved_found)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cur_q   <= '0;
      saved_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: alert beats pin, pin beats rotation.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    if (alert) begin
      // A repeated alert only restarts the hold; the pre-alert index is kept.
      state_d = StAlert;
      if (state_q != StAlert) saved_d = cur_q;
      cur_d = 2'd0;
      cnt_d = HoldLoad;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (cur_found) begin
            state_d = StShow;
            cur_d   = cur_next;
            cnt_d   = DwellLoad;
          end
        end
        StShow: begin
          if (pin_en && valid_q[pin_sel]) begin
            cur_d = pin_sel;
            cnt_d = DwellLoad;
          end else if (!cur_found) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (!valid_q[cur_q] || cnt_q == '0) begin
            cur_d = cur_next;
            cnt_d = DwellLoad;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        StAlert: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (valid_q[saved_q]) begin
            state_d = StShow;
            cur_d   = saved_q;
            cnt_d   = DwellLoad;
          end else if (saved_found) begin
            state_d = StShow;
            cur_d   = saved_next;
            cnt_d   = DwellLoad;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Snapshot capture; load wins over clear in the same cycle.
  always_comb begin
    valid_d = (valid_q & ~clear) | load;
    for (int i = 0; i < NSRC; i++) begin
      snap_d[i] = load[i] ? src_data[16*i +: 16] : snap_q[i];
    end
  end

  // Output next values: data lags cur_src by one cycle, switched marks an index change.
  always_comb begin
    data_d = (state_q == StIdle) ? 16'h0000 : snap_q[cur_q];
    sw_d   = (cur_d != cur_q);
  end

  // Snapshot and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) snap_q[i] <= '0;
      valid_q <= '0;
      data_q  <= '0;
      any_q   <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) snap_q[i] <= snap_d[i];
      valid_q <= valid_d;
      data_q  <= data_d;
      any_q   <= |valid_q;
      sw_q    <= sw_d;
    end
  end

  assign data      = data_q;
  assign cur_src   = cur_q;
  assign any_valid = any_q;
  assign switched  = sw_q;

endmodule

// File: tb/tb_led_disp_sched.sv
// Directed bench for led_disp_sched with short dwell and alert hold.
module tb_led_disp_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  load;
  logic [3:0]  clear;
  logic [63:0] src_data;
  logic        pin_en;
  logic [1:0]  pin_sel;
  logic        alert;
  logic [15:0] data;
  logic [1:0]  cur_src;
  logic        any_valid;
  logic        switched;

  int n_tests = 0;
  int n_fail  = 0;

  led_disp_sched #(
    .DWELL      (4),
    .ALERT_HOLD (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .clear     (clear),
    .src_data  (src_data),
    .pin_en    (pin_en),
    .pin_sel   (pin_sel),
    .alert     (alert),
    .data      (data),
    .cur_src   (cur_src),
    .any_valid (any_valid),
    .switched  (switched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  ld;
    logic [3:0]  cl;
    logic [63:0] sd;
    logic [15:0] ed;
    logic [1:0]  ec;
    logic        ea;
    logic        es;
  } vec_t;

  vec_t tbl [15];

  // Apply one cycle of inputs, then settle 1 time unit past the edge.
  task automatic drive(input logic [3:0] ld, input logic [3:0] cl, input logic [63:0] sd,
                       input logic pe, input logic [1:0] ps, input logic al);
    load     = ld;
    clear    = cl;
    src_data = sd;
    pin_en   = pe;
    pin_sel  = ps;
    alert    = al;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] ed, input logic [1:0] ec,
                     input logic ea, input logic es);
    n_tests++;
    if (data !== ed || cur_src !== ec || any_valid !== ea || switched !== es) begin
      n_fail++;
      $display("FAIL %s: got data=%h cur=%0d any=%b sw=%b, want data=%h cur=%0d any=%b sw=%b",
               nm, data, cur_src, any_valid, switched, ed, ec, ea, es);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("reset", 16'h0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // Rotation over src1/src3, then load+clear together and a live update of src1.
    tbl[0]  = '{4'b1010, 4'b0000, 64'hBEEF_0000_1234_0000, 16'h0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0000, 4'b0000, 64'h0, 16'h0000, 2'd1, 1'b1, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0000, 64'h0, 16'h1234, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 64'h0, 16'h1234, 2'd1, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 64'h0, 16'h1234, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 64'h0, 16'h1234, 2'd3, 1'b1, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 64'h0, 16'hBEEF, 2'd3, 1'b1, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 64'h0, 16'hBEEF, 2'd3, 1'b1, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 64'h0, 16'hBEEF, 2'd3, 1'b1, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 64'h0, 16'hBEEF, 2'd1, 1'b1, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 64'h0, 16'h1234, 2'd1, 1'b1, 1'b0};
    tbl[11] = '{4'b0010, 4'b0010, 64'h0000_0000_CAFE_0000, 16'h1234, 2'd1, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 64'h0, 16'hCAFE, 2'd1, 1'b1, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 64'h0, 16'hCAFE, 2'd3, 1'b1, 1'b1};
    tbl[14] = '{4'b0000, 4'b0000, 64'h0, 16'hBEEF, 2'd3, 1'b1, 1'b0};

    // Loads while reset is held must not take effect.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0, 1'b0);
      chk("rst_hold", 16'h0000, 2'd0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
      chk("idle_after_rst", 16'h0000, 2'd0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].ld, tbl[i].cl, tbl[i].sd, 1'b0, 2'd0, 1'b0);
      chk($sformatf("table[%0d]", i), tbl[i].ed, tbl[i].ec, tbl[i].ea, tbl[i].es);
    end

    // Sole valid source never switches; clearing it drops to idle.
    do_reset();
    drive(4'b0100, 4'h0, 64'h0000_2222_0000_0000, 1'b0, 2'd0, 1'b0);
    chk("solo_load", 16'h0000, 2'd0, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("solo_enter", 16'h0000, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
      chk("solo_hold", 16'h2222, 2'd2, 1'b1, 1'b0);
    end
    drive(4'h0, 4'b0100, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("solo_clear0", 16'h2222, 2'd2, 1'b1, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("solo_clear1", 16'h2222, 2'd2, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("solo_idle", 16'h0000, 2'd2, 1'b0, 1'b0);

    // Pin on source 2, then clear it while pinned.
    do_reset();
    drive(4'hF, 4'h0, 64'hA003_A002_A001_A000, 1'b0, 2'd0, 1'b0);
    chk("pin_load", 16'h0000, 2'd0, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("pin_enter", 16'h0000, 2'd1, 1'b1, 1'b1);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("pin_show1", 16'hA001, 2'd1, 1'b1, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b1, 2'd2, 1'b0);
    chk("pin_lock", 16'hA001, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      drive(4'h0, 4'h0, 64'h0, 1'b1, 2'd2, 1'b0);
      chk("pin_hold", 16'hA002, 2'd2, 1'b1, 1'b0);
    end
    drive(4'h0, 4'b0100, 64'h0, 1'b1, 2'd2, 1'b0);
    chk("pin_clear0", 16'hA002, 2'd2, 1'b1, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b1, 2'd2, 1'b0);
    chk("pin_resume", 16'hA002, 2'd3, 1'b1, 1'b1);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("pin_show3", 16'hA003, 2'd3, 1'b1, 1'b0);

    // Alert while showing src3 (src0 never loaded).
    do_reset();
    drive(4'b1000, 4'h0, 64'h3333_0000_0000_0000, 1'b0, 2'd0, 1'b0);
    chk("al_load", 16'h0000, 2'd0, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al_enter", 16'h0000, 2'd3, 1'b1, 1'b1);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al_show3", 16'h3333, 2'd3, 1'b1, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b1);
    chk("al_start", 16'h3333, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
      chk("al_hold", 16'h0000, 2'd0, 1'b1, 1'b0);
    end
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al_return", 16'h0000, 2'd3, 1'b1, 1'b1);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al_back3", 16'h3333, 2'd3, 1'b1, 1'b0);

    // Second alert at hold cycle 4 restarts the hold.
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b1);
    chk("al2_start", 16'h3333, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
      chk("al2_hold_a", 16'h0000, 2'd0, 1'b1, 1'b0);
    end
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b1);
    chk("al2_retrig", 16'h0000, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
      chk("al2_hold_b", 16'h0000, 2'd0, 1'b1, 1'b0);
    end
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al2_return", 16'h0000, 2'd3, 1'b1, 1'b1);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al2_back3", 16'h3333, 2'd3, 1'b1, 1'b0);

    // Saved source cleared during alert: return goes to the next valid one.
    drive(4'b0010, 4'h0, 64'h0000_0000_1111_0000, 1'b0, 2'd0, 1'b0);
    chk("al3_load1", 16'h3333, 2'd3, 1'b1, 1'b0);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b1);
    chk("al3_start", 16'h3333, 2'd0, 1'b1, 1'b1);
    drive(4'h0, 4'b1000, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al3_clear3", 16'h0000, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
      chk("al3_hold", 16'h0000, 2'd0, 1'b1, 1'b0);
    end
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al3_return", 16'h0000, 2'd1, 1'b1, 1'b1);
    drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
    chk("al3_show1", 16'h1111, 2'd1, 1'b1, 1'b0);

    // Reset mid-show with alert and loads asserted wins.
    reset = 1'b1;
    drive(4'hF, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0, 1'b1);
    chk("rst_mid", 16'h0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(4'h0, 4'h0, 64'h0, 1'b0, 2'd0, 1'b0);
      chk("rst_mid_after", 16'h0000, 2'd0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
